// File: rtl/mem_wr_pkg.sv
// Field layout shared by the MEM and WR stages; both sides connect through these structs.
package mem_wr_pkg;

   localparam int W_WORD     = 32;
   localparam int W_MULT     = 64;
   localparam int W_REG      = 5;
   localparam int W_MEMTOREG = 2;
   localparam int W_OP       = 6;
   localparam int W_SEL      = 3;
   localparam int W_CP0OP    = 3;

   localparam int MEMWR_DATA_W = 5 * W_WORD + W_MULT + 2 * W_REG + W_MEMTOREG + W_OP + W_SEL;
   localparam int MEMWR_CTRL_W = 4 + W_CP0OP;

   typedef struct packed {
      logic [W_WORD-1:0]     dout;
      logic [W_WORD-1:0]     result;
      logic [W_WORD-1:0]     hl;
      logic [W_WORD-1:0]     busa_mux2;
      logic [W_WORD-1:0]     cp0_dout;
      logic [W_MULT-1:0]     mult;
      logic [W_REG-1:0]      rw;
      logic [W_REG-1:0]      cs;
      logic [W_MEMTOREG-1:0] memtoreg;
      logic [W_OP-1:0]       op;
      logic [W_SEL-1:0]      sel;
   } memwr_data_t;

   typedef struct packed {
      logic                 reg_wr;
      logic                 mult_wr;
      logic                 low_in;
      logic                 high_in;
      logic [W_CP0OP-1:0]   cp0op;
   } memwr_ctrl_t;

   // Write-enable style bits must never leave a slot that holds a bubble.
   function automatic logic [MEMWR_CTRL_W-1:0] gate_ctrl(input logic vld,
                                                         input logic [MEMWR_CTRL_W-1:0] ctrl);
      return vld ? ctrl : '0;
   endfunction

endpackage

// File: rtl/mem_wr_slot.sv
// One MEM->WR register slot: load, hold, flush (kills valid/ctrl) and reset.
module mem_wr_slot
   import mem_wr_pkg::*;
#(
   parameter int DATA_W = MEMWR_DATA_W,
   parameter int CTRL_W = MEMWR_CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              load_i,
   input  logic              src_vld_i,
   input  logic [DATA_W-1:0] src_data_i,
   input  logic [CTRL_W-1:0] src_ctrl_i,
   output logic              vld_o,
   output logic [DATA_W-1:0] data_o,
   output logic [CTRL_W-1:0] ctrl_o
);

   logic              vld_q,  vld_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;

   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      ctrl_d = ctrl_q;
      if (flush_i) begin
         vld_d  = 1'b0;
         ctrl_d = '0;
      end else if (load_i) begin
         vld_d  = src_vld_i;
         data_d = src_data_i;
         ctrl_d = src_vld_i ? src_ctrl_i : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= 1'b0;
         data_q <= '0;
         ctrl_q <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
         ctrl_q <= ctrl_d;
      end
   end

   assign vld_o  = vld_q;
   assign data_o = data_q;
   assign ctrl_o = ctrl_q;

endmodule

// File: rtl/mem_wr_pipe.sv
// MEM->WR pipeline register: STAGES slots, valid/ready handshake, flush and bubble collapsing.
module mem_wr_pipe
   import mem_wr_pkg::*;
#(
   parameter int DATA_W = MEMWR_DATA_W,
   parameter int CTRL_W = MEMWR_CTRL_W,
   parameter int STAGES = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_data,
   input  logic [CTRL_W-1:0]            in_ctrl,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic [CTRL_W-1:0]            out_ctrl,
   output logic [$clog2(STAGES+1)-1:0]  occupancy
);

   localparam int OCC_W = $clog2(STAGES + 1);

   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] load;
   logic [DATA_W-1:0] dat [STAGES];
   logic [CTRL_W-1:0] ctl [STAGES];
   logic              carry;
   logic [OCC_W-1:0]  occ;

   // Advance chain walks from the output back: a slot may move if anything downstream has room.
   always_comb begin
      adv   = '0;
      load  = '0;
      carry = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         adv[i]  = carry;
         load[i] = ~vld[i] | carry;
         carry   = carry | ~vld[i];
      end
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_slot
      if (g == 0) begin : g_head
         mem_wr_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .flush_i   (flush),
            .load_i    (load[g]),
            .src_vld_i (in_valid),
            .src_data_i(in_data),
            .src_ctrl_i(in_ctrl),
            .vld_o     (vld[g]),
            .data_o    (dat[g]),
            .ctrl_o    (ctl[g])
         );
      end else begin : g_body
         mem_wr_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .flush_i   (flush),
            .load_i    (load[g]),
            .src_vld_i (vld[g-1]),
            .src_data_i(dat[g-1]),
            .src_ctrl_i(ctl[g-1]),
            .vld_o     (vld[g]),
            .data_o    (dat[g]),
            .ctrl_o    (ctl[g])
         );
      end
   end

   always_comb begin
      occ = '0;
      for (int i = 0; i < STAGES; i++) begin
         occ = occ + OCC_W'(vld[i]);
      end
   end

   assign in_ready  = load[0];
   assign out_valid = vld[STAGES-1];
   assign out_data  = dat[STAGES-1];
   assign out_ctrl  = ctl[STAGES-1];
   assign occupancy = occ;

endmodule

// File: tb/tb_mem_wr_pipe.sv
// Directed and randomised checks of mem_wr_pipe at STAGES = 1, 2 and 3.
module tb_mem_wr_pipe;
   import mem_wr_pkg::*;

   localparam int DW = MEMWR_DATA_W;
   localparam int CW = MEMWR_CTRL_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          fl1 = 0, iv1 = 0, ir1, or1 = 0, ov1;
   logic [DW-1:0] d1 = '0, od1;
   logic [CW-1:0] c1 = '0, oc1;
   logic [0:0]    occ1;

   logic          fl2 = 0, iv2 = 0, ir2, or2 = 0, ov2;
   logic [DW-1:0] d2 = '0, od2;
   logic [CW-1:0] c2 = '0, oc2;
   logic [1:0]    occ2;

   logic          fl3 = 0, iv3 = 0, ir3, or3 = 0, ov3;
   logic [DW-1:0] d3 = '0, od3;
   logic [CW-1:0] c3 = '0, oc3;
   logic [1:0]    occ3;

   mem_wr_pipe #(.STAGES(1)) u1 (
      .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
      .in_data(d1), .in_ctrl(c1), .out_valid(ov1), .out_ready(or1),
      .out_data(od1), .out_ctrl(oc1), .occupancy(occ1));

   mem_wr_pipe #(.STAGES(2)) u2 (
      .clk(clk), .rst(rst), .flush(fl2), .in_valid(iv2), .in_ready(ir2),
      .in_data(d2), .in_ctrl(c2), .out_valid(ov2), .out_ready(or2),
      .out_data(od2), .out_ctrl(oc2), .occupancy(occ2));

   mem_wr_pipe #(.STAGES(3)) u3 (
      .clk(clk), .rst(rst), .flush(fl3), .in_valid(iv3), .in_ready(ir3),
      .in_data(d3), .in_ctrl(c3), .out_valid(ov3), .out_ready(or3),
      .out_data(od3), .out_ctrl(oc3), .occupancy(occ3));

   int ncmp = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   function automatic logic [CW-1:0] tag_ctrl(input int t);
      return {t[5:0], 1'b1};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL timeout ncmp=%0d", ncmp);
      $fatal(1, "timeout");
   end

   initial begin
      int q[$];
      int tag;

      // reset
      tick(); tick();
      rst = 1'b0;
      mid();
      chk("rst_ov1", ov1, 0);  chk("rst_od1", od1, 0);  chk("rst_oc1", oc1, 0);
      chk("rst_occ1", occ1, 0); chk("rst_ir1", ir1, 1);
      chk("rst_ov3", ov3, 0);  chk("rst_od3", od3, 0);  chk("rst_oc3", oc3, 0);
      chk("rst_occ3", occ3, 0); chk("rst_ir3", ir3, 1);
      chk("rst_ov2", ov2, 0);  chk("rst_oc2", oc2, 0);
      tick();

      // STAGES=1 streaming
      or1 = 1;
      for (int i = 1; i <= 8; i++) begin
         iv1 = 1; d1 = DW'(i); c1 = 7'h7F;
         mid();
         chk("s1_ir", ir1, 1);
         if (i == 1) begin
            chk("s1_ov_first", ov1, 0);
         end else begin
            chk("s1_ov", ov1, 1);
            chk("s1_od", od1, i - 1);
            chk("s1_oc", oc1, 7'h7F);
         end
         tick();
      end
      iv1 = 0;
      mid();
      chk("s1_od_last", od1, 8); chk("s1_ov_last", ov1, 1);
      tick();
      mid();
      chk("s1_ov_drain", ov1, 0); chk("s1_oc_drain", oc1, 0);
      tick();

      // STAGES=3 fill under backpressure, then release
      or3 = 0;
      for (int k = 0; k < 3; k++) begin
         iv3 = 1; d3 = DW'(8'h10 + k); c3 = CW'(k + 1);
         mid();
         chk("s3_fill_ir", ir3, 1);
         tick();
      end
      iv3 = 0;
      mid();
      chk("s3_full_occ", occ3, 3); chk("s3_full_ir", ir3, 0);
      chk("s3_full_od", od3, 8'h10); chk("s3_full_oc", oc3, 1);
      tick();
      mid();
      chk("s3_hold_od", od3, 8'h10); chk("s3_hold_occ", occ3, 3);
      tick();
      or3 = 1;
      mid();
      chk("s3_rel_ir", ir3, 1); chk("s3_rel_od", od3, 8'h10);
      tick();
      mid();
      chk("s3_out1_od", od3, 8'h11); chk("s3_out1_oc", oc3, 2); chk("s3_out1_occ", occ3, 2);
      tick();
      mid();
      chk("s3_out2_od", od3, 8'h12); chk("s3_out2_oc", oc3, 3); chk("s3_out2_occ", occ3, 1);
      tick();
      mid();
      chk("s3_empty_ov", ov3, 0); chk("s3_empty_oc", oc3, 0); chk("s3_empty_occ", occ3, 0);
      tick();

      // STAGES=3 single entry collapses forward
      or3 = 0; iv3 = 1; d3 = DW'(8'h20); c3 = 7'h05;
      mid();
      tick();
      iv3 = 0;
      mid();
      chk("bub_e1_occ", occ3, 1); chk("bub_e1_ov", ov3, 0); chk("bub_e1_oc", oc3, 0);
      chk("bub_e1_ir", ir3, 1);
      tick();
      mid();
      chk("bub_e2_ov", ov3, 0); chk("bub_e2_occ", occ3, 1);
      tick();
      mid();
      chk("bub_e3_ov", ov3, 1); chk("bub_e3_od", od3, 8'h20); chk("bub_e3_oc", oc3, 7'h05);
      chk("bub_e3_occ", occ3, 1); chk("bub_e3_ir", ir3, 1);
      tick();
      or3 = 1;
      mid();
      tick();
      mid();
      chk("bub_drain_occ", occ3, 0);
      tick();

      // STAGES=2 flush while full
      or2 = 0; iv2 = 1; d2 = DW'(8'h30); c2 = 7'h7F;
      mid();
      tick();
      d2 = DW'(8'h31);
      mid();
      tick();
      d2 = DW'(8'h3F);
      mid();
      chk("fl_full_occ", occ2, 2); chk("fl_full_ir", ir2, 0); chk("fl_full_od", od2, 8'h30);
      tick();
      fl2 = 1; or2 = 1;
      mid();
      chk("fl_xfer_ov", ov2, 1); chk("fl_xfer_od", od2, 8'h30);
      tick();
      fl2 = 0; iv2 = 0;
      mid();
      chk("fl_after_occ", occ2, 0); chk("fl_after_ov", ov2, 0); chk("fl_after_oc", oc2, 0);
      tick(); tick();
      mid();
      chk("fl_dropped_ov", ov2, 0);
      tick();

      // STAGES=3 reset together with flush while full
      or3 = 0;
      for (int k = 0; k < 3; k++) begin
         iv3 = 1; d3 = DW'(8'h40 + k); c3 = 7'h7F;
         mid();
         tick();
      end
      iv3 = 0;
      mid();
      chk("rf_full_occ", occ3, 3);
      tick();
      rst = 1; fl3 = 1; iv3 = 1; d3 = DW'(8'h4F); or3 = 1;
      mid();
      tick();
      rst = 0; fl3 = 0; iv3 = 0; or3 = 0;
      mid();
      chk("rf_ov", ov3, 0); chk("rf_od", od3, 0); chk("rf_oc", oc3, 0);
      chk("rf_occ", occ3, 0); chk("rf_ir", ir3, 1);
      tick();
      iv3 = 1; d3 = DW'(8'h50); c3 = 7'h33;
      mid();
      tick();
      iv3 = 0;
      mid();
      chk("rf_lat1_ov", ov3, 0); chk("rf_lat1_occ", occ3, 1);
      tick();
      mid();
      chk("rf_lat2_ov", ov3, 0);
      tick();
      mid();
      chk("rf_lat3_ov", ov3, 1); chk("rf_lat3_od", od3, 8'h50); chk("rf_lat3_oc", oc3, 7'h33);
      tick();
      or3 = 1;
      mid();
      tick();
      mid();
      chk("rf_drain_occ", occ3, 0);
      tick();

      // STAGES=3 random traffic against a queue model
      tag = 1;
      q.delete();
      for (int n = 0; n < 3000; n++) begin
         iv3 = ($urandom_range(0, 3) != 0);
         or3 = ($urandom_range(0, 3) != 0);
         fl3 = ($urandom_range(0, 31) == 0);
         d3  = DW'(tag);
         c3  = tag_ctrl(tag);
         mid();
         chk("rnd_occ", occ3, q.size());
         chk("rnd_ir", ir3, (or3 || q.size() < 3));
         if (ov3) begin
            chk("rnd_nonempty", (q.size() > 0), 1);
            if (q.size() > 0) begin
               chk("rnd_od", od3, q[0]);
               chk("rnd_oc", oc3, tag_ctrl(q[0]));
            end
         end else begin
            chk("rnd_oc_bubble", oc3, 0);
         end
         if (ov3 && or3 && q.size() > 0) void'(q.pop_front());
         if (fl3) begin
            q.delete();
         end else if (iv3 && ir3) begin
            q.push_back(tag);
            tag++;
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
